// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter.
//   state_t   : FSM encoding (IDLE, COUNT, DONE)
//   LOCK_HITS : consecutive in-tolerance windows needed to declare lock
//   gate_len  : gate window length in Clk cycles for a given GateSel
// Optional feature macro: FREQ_LOCK_DET_EN (lock detector in the top level).
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int LOCK_HITS = 3;

    // Window length is 2^(min_log2 + gate_sel) Clk cycles.
    function automatic int unsigned gate_len(input logic [1:0] gate_sel,
                                             input int unsigned min_log2);
        return 32'd1 << (min_log2 + 32'(gate_sel));
    endfunction

endpackage

// File: rtl/freq_meter_if.sv
// Request/result bundle of the frequency meter.
// Handshake: Start is a one-cycle request, only honoured while the meter is idle
// (Busy low). Valid is a one-cycle strobe; Count/Overflow (and Locked) change only
// in the Valid cycle and hold until the next Valid or reset. There is no back-pressure.
//   master : Start, GateSel (+ Target, Tol) out; Busy, Valid, Count, Overflow,
//            dbg_state (+ Locked) in
//   slave  : mirror of master
// Optional feature macro: FREQ_LOCK_DET_EN adds Target, Tol and Locked.
interface freq_meter_if #(
    parameter int CNT_W = 12
);
    import freq_meter_pkg::*;

    logic             Start;
    logic [1:0]       GateSel;
    logic             Busy;
    logic             Valid;
    logic [CNT_W-1:0] Count;
    logic             Overflow;
    state_t           dbg_state;
`ifdef FREQ_LOCK_DET_EN
    logic [CNT_W-1:0] Target;
    logic [CNT_W-1:0] Tol;
    logic             Locked;

    modport master (output Start, GateSel, Target, Tol,
                    input  Busy, Valid, Count, Overflow, dbg_state, Locked);
    modport slave  (input  Start, GateSel, Target, Tol,
                    output Busy, Valid, Count, Overflow, dbg_state, Locked);
`else
    modport master (output Start, GateSel,
                    input  Busy, Valid, Count, Overflow, dbg_state);
    modport slave  (input  Start, GateSel,
                    output Busy, Valid, Count, Overflow, dbg_state);
`endif

endinterface

// File: rtl/freq_meter_edge_sync.sv
// Synchronizer plus rising-edge detector for an asynchronous input.
//   Clk, Reset : system clock, synchronous active-high reset
//   Din        : asynchronous input
//   EdgePulse  : one-cycle pulse per rising edge of Din, SYNC_STAGES+1 cycles late
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Din,
    output logic EdgePulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q    <= '0;
            hist_q    <= 1'b0;
            EdgePulse <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], Din};
            hist_q    <= sync_q[SYNC_STAGES-1];
            // Registered so the pulse is glitch-free for the counter.
            EdgePulse <= sync_q[SYNC_STAGES-1] & ~hist_q;
        end
    end

endmodule

// File: rtl/freq_meter.sv
// Frequency meter: counts rising edges of Fmeas during a gate window of
// 2^(GATE_MIN_LOG2+GateSel) Clk cycles and reports the result with a Valid strobe.
//   Clk, Reset : system clock, synchronous active-high reset
//   Fmeas      : asynchronous clock under measurement, f(Fmeas) < f(Clk)/2
//   bus        : freq_meter_if slave (Start/GateSel in, Busy/Valid/Count/Overflow out)
// Optional feature macro: FREQ_LOCK_DET_EN adds a Target/Tol lock detector
// driving bus.Locked.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W         = 12,
    parameter int GATE_MIN_LOG2 = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Fmeas,
    freq_meter_if.slave   bus
);

    // Longest window is 2^(GATE_MIN_LOG2+3) cycles; counter runs 0 .. len-1.
    localparam int GATE_W = GATE_MIN_LOG2 + 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [GATE_W-1:0] gate_cnt;
    logic [1:0]        gate_sel_q;
    logic [CNT_W-1:0]  edge_cnt;
    logic              ovf_flag;
    logic              busy_q;
    logic              valid_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              edge_pulse;

    logic              last_cycle;
    logic [CNT_W-1:0]  edge_cnt_next;
    logic              ovf_next;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
        .Clk       (Clk),
        .Reset     (Reset),
        .Din       (Fmeas),
        .EdgePulse (edge_pulse)
    );

    always_comb begin
        last_cycle    = (gate_cnt == GATE_W'(gate_len(gate_sel_q, GATE_MIN_LOG2) - 1));
        edge_cnt_next = edge_cnt;
        ovf_next      = ovf_flag;
        if (edge_pulse) begin
            if (edge_cnt == CNT_MAX) ovf_next = 1'b1;
            else                     edge_cnt_next = edge_cnt + 1'b1;
        end
    end

`ifdef FREQ_LOCK_DET_EN
    logic [1:0]       hit_cnt;
    logic [1:0]       hit_cnt_next;
    logic [CNT_W-1:0] diff;
    logic             hit;
    logic             locked_q;

    // Evaluated against the result being committed this cycle.
    always_comb begin
        diff         = (edge_cnt_next >= bus.Target) ? edge_cnt_next - bus.Target
                                                     : bus.Target - edge_cnt_next;
        hit          = !ovf_next && (diff <= bus.Tol);
        hit_cnt_next = 2'd0;
        if (hit) begin
            hit_cnt_next = (hit_cnt == 2'(LOCK_HITS)) ? hit_cnt : hit_cnt + 2'd1;
        end
    end

    assign bus.Locked = locked_q;
`endif

    // Result registers are loaded on the COUNT->DONE edge so they are visible
    // together with Valid during the DONE cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            gate_sel_q <= 2'd0;
            edge_cnt   <= '0;
            ovf_flag   <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef FREQ_LOCK_DET_EN
            hit_cnt    <= 2'd0;
            locked_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (bus.Start) begin
                        state      <= COUNT;
                        busy_q     <= 1'b1;
                        gate_sel_q <= bus.GateSel;
                        gate_cnt   <= '0;
                        edge_cnt   <= '0;
                        ovf_flag   <= 1'b0;
                    end
                end
                COUNT: begin
                    gate_cnt <= gate_cnt + 1'b1;
                    edge_cnt <= edge_cnt_next;
                    ovf_flag <= ovf_next;
                    if (last_cycle) begin
                        state      <= DONE;
                        valid_q    <= 1'b1;
                        count_q    <= edge_cnt_next;
                        overflow_q <= ovf_next;
`ifdef FREQ_LOCK_DET_EN
                        hit_cnt    <= hit_cnt_next;
                        locked_q   <= (hit_cnt_next == 2'(LOCK_HITS));
`endif
                    end
                end
                DONE: begin
                    // Start here is dropped; the next request is taken in IDLE.
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Valid     = valid_q;
    assign bus.Count     = count_q;
    assign bus.Overflow  = overflow_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a 12-bit instance and an 8-bit instance share
// clock, reset and the measured clock. Expected values are hand-computed from
// the window length and the Fmeas divider.
module tb_freq_meter;
    import freq_meter_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Fmeas = clk / fm_div (fm_div even), static low when fm_div == 0.
    int   fm_div = 0;
    int   fm_cnt = 0;
    logic fmeas  = 1'b0;
    always @(negedge clk) begin
        if (fm_div == 0) begin
            fmeas  <= 1'b0;
            fm_cnt <= 0;
        end else if (fm_cnt >= fm_div / 2 - 1) begin
            fmeas  <= ~fmeas;
            fm_cnt <= 0;
        end else begin
            fm_cnt <= fm_cnt + 1;
        end
    end

    freq_meter_if #(.CNT_W(12)) m_if ();
    freq_meter_if #(.CNT_W(8))  s_if ();

    freq_meter #(.CNT_W(12)) u_dut (
        .Clk   (clk),
        .Reset (rst),
        .Fmeas (fmeas),
        .bus   (m_if)
    );

    freq_meter #(.CNT_W(8)) u_dut8 (
        .Clk   (clk),
        .Reset (rst),
        .Fmeas (fmeas),
        .bus   (s_if)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        logic in_rng;
        in_rng = (obs >= lo) && (obs <= hi);
        n_checks++;
        assert (in_rng === 1'b1)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // ---------------- driver ----------------
    // Runs one window on the selected instance. cyc = edges from the Start-accept
    // edge until Valid is seen (-1 on timeout). GateSel switches to gs2 at edge chg_at.
    task automatic run_win(input bit use8, input logic [1:0] gs, input int chg_at,
                           input logic [1:0] gs2, output int cyc, output int cnt,
                           output int ovf, output int lck);
        @(posedge clk); #1;
        if (use8) begin s_if.GateSel = gs; s_if.Start = 1'b1; end
        else      begin m_if.GateSel = gs; m_if.Start = 1'b1; end
        @(posedge clk); #1;
        s_if.Start = 1'b0;
        m_if.Start = 1'b0;
        cyc = -1;
        for (int i = 1; i <= 5000; i++) begin
            if (i == chg_at) begin
                if (use8) s_if.GateSel = gs2;
                else      m_if.GateSel = gs2;
            end
            @(posedge clk); #1;
            if ((use8 ? s_if.Valid : m_if.Valid) === 1'b1) begin
                cyc = i;
                break;
            end
        end
        cnt = use8 ? int'(s_if.Count) : int'(m_if.Count);
        ovf = use8 ? int'(s_if.Overflow) : int'(m_if.Overflow);
        lck = 0;
`ifdef FREQ_LOCK_DET_EN
        lck = use8 ? int'(s_if.Locked) : int'(m_if.Locked);
`endif
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc, cnt, ovf, lck, nvalid;

        m_if.Start = 1'b0; m_if.GateSel = 2'd0;
        s_if.Start = 1'b0; s_if.GateSel = 2'd0;
`ifdef FREQ_LOCK_DET_EN
        m_if.Target = 12'd32; m_if.Tol = 12'd1;
        s_if.Target = 8'd0;   s_if.Tol = 8'd0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_busy",  int'(m_if.Busy), 0);
        check("rst_valid", int'(m_if.Valid), 0);
        check("rst_count", int'(m_if.Count), 0);
        check("rst_ovf",   int'(m_if.Overflow), 0);
        check("rst_state", int'(m_if.dbg_state), int'(IDLE));

        // Clk/8, 256-cycle window -> 32 edges
        fm_div = 8;
        repeat (20) @(posedge clk);
        run_win(1'b0, 2'd0, 0, 2'd0, cyc, cnt, ovf, lck);
        check("t1_latency", cyc, 256);
        check_rng("t1_count", cnt, 31, 33);
        check("t1_ovf", ovf, 0);
        check("t1_busy_done", int'(m_if.Busy), 1);
        @(posedge clk); #1;
        check("t1_valid_1cyc", int'(m_if.Valid), 0);
        check("t1_busy_idle", int'(m_if.Busy), 0);
        repeat (10) @(posedge clk);
        #1 check_rng("t1_count_hold", int'(m_if.Count), 31, 33);

        // Static Fmeas; Start pulses while busy and on the DONE cycle are dropped
        fm_div = 0;
        repeat (10) @(posedge clk);
        #1;
        m_if.GateSel = 2'd0; m_if.Start = 1'b1;
        @(posedge clk); #1;
        m_if.Start = 1'b0;
        nvalid = 0;
        cnt = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (m_if.Valid === 1'b1) begin
                nvalid++;
                cnt = int'(m_if.Count);
                ovf = int'(m_if.Overflow);
                m_if.Start = 1'b1;
            end else begin
                m_if.Start = (i == 49 || i == 254);
            end
        end
        m_if.Start = 1'b0;
        check("t3_nvalid", nvalid, 1);
        check("t3_count", cnt, 0);
        check("t3_ovf", ovf, 0);
        check("t3_busy_after", int'(m_if.Busy), 0);

        // Reset 100 cycles into a window
        fm_div = 8;
        repeat (10) @(posedge clk);
        #1 m_if.Start = 1'b1;
        @(posedge clk); #1;
        m_if.Start = 1'b0;
        repeat (100) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t4_valid", int'(m_if.Valid), 0);
        check("t4_busy", int'(m_if.Busy), 0);
        check("t4_count", int'(m_if.Count), 0);
        check("t4_ovf", int'(m_if.Overflow), 0);
        check("t4_state", int'(m_if.dbg_state), int'(IDLE));
        nvalid = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (m_if.Valid === 1'b1) nvalid++;
        end
        check("t4_no_valid", nvalid, 0);
        run_win(1'b0, 2'd0, 0, 2'd0, cyc, cnt, ovf, lck);
        check("t4_latency", cyc, 256);
        check_rng("t4_count", cnt, 31, 33);

        // Clk/16, 512-cycle window; GateSel changed mid-window
        fm_div = 16;
        repeat (20) @(posedge clk);
        run_win(1'b0, 2'd1, 0, 2'd1, cyc, cnt, ovf, lck);
        check("t5_latency", cyc, 512);
        check_rng("t5_count", cnt, 31, 33);
        run_win(1'b0, 2'd1, 200, 2'd3, cyc, cnt, ovf, lck);
        check("t5_chg_latency", cyc, 512);
        check_rng("t5_chg_count", cnt, 31, 33);

        // Clk/4, 2048-cycle window: 512 edges; saturates the 8-bit instance
        fm_div = 4;
        repeat (20) @(posedge clk);
        run_win(1'b0, 2'd3, 0, 2'd3, cyc, cnt, ovf, lck);
        check("t2w_latency", cyc, 2048);
        check_rng("t2w_count", cnt, 511, 513);
        check("t2w_ovf", ovf, 0);
        run_win(1'b1, 2'd3, 0, 2'd3, cyc, cnt, ovf, lck);
        check("t2_latency", cyc, 2048);
        check("t2_count", cnt, 255);
        check("t2_ovf", ovf, 1);

        // 8-bit instance below saturation
        fm_div = 8;
        repeat (20) @(posedge clk);
        run_win(1'b1, 2'd0, 0, 2'd0, cyc, cnt, ovf, lck);
        check_rng("t2n_count", cnt, 31, 33);
        check("t2n_ovf", ovf, 0);

`ifdef FREQ_LOCK_DET_EN
        // Target 32, Tol 1: three hits lock, one miss unlocks
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_rst_locked", int'(m_if.Locked), 0);
        fm_div = 8;
        repeat (20) @(posedge clk);
        run_win(1'b0, 2'd0, 0, 2'd0, cyc, cnt, ovf, lck);
        check("t6_lock_w1", lck, 0);
        run_win(1'b0, 2'd0, 0, 2'd0, cyc, cnt, ovf, lck);
        check("t6_lock_w2", lck, 0);
        run_win(1'b0, 2'd0, 0, 2'd0, cyc, cnt, ovf, lck);
        check("t6_lock_w3", lck, 1);
        fm_div = 4;
        repeat (20) @(posedge clk);
        run_win(1'b0, 2'd0, 0, 2'd0, cyc, cnt, ovf, lck);
        check("t6_lock_w4", lck, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
